// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: default sizes and FSM state encoding.
package interrupt_controller_pkg;

   localparam int unsigned NUM_IRQ_DEF  = 8;
   localparam int unsigned ID_WIDTH_DEF = 3;
   localparam int unsigned STATE_W      = 2;

   localparam logic [STATE_W-1:0] S_IDLE    = 2'd0;
   localparam logic [STATE_W-1:0] S_REQUEST = 2'd1;
   localparam logic [STATE_W-1:0] S_SERVICE = 2'd2;

endpackage

// File: rtl/interrupt_controller_if.sv
// Bundle of IRQ lines, mask access and CPU handshake between peripherals/CPU and the controller.
interface interrupt_controller_if
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned NUM_IRQ  = NUM_IRQ_DEF,
   parameter int unsigned ID_WIDTH = ID_WIDTH_DEF
);

   logic [NUM_IRQ-1:0]  irq_in;
   logic                mask_wr;
   logic [NUM_IRQ-1:0]  mask_data;
   logic [NUM_IRQ-1:0]  mask;
   logic [NUM_IRQ-1:0]  pending;
   logic                cpu_int;
   logic [ID_WIDTH-1:0] int_id;
   logic                int_ack;
   logic                int_done;

   // System side: peripherals drive the lines, CPU drives mask and handshake
   modport master (
      output irq_in, mask_wr, mask_data, int_ack, int_done,
      input  mask, pending, cpu_int, int_id
   );

   modport slave (
      input  irq_in, mask_wr, mask_data, int_ack, int_done,
      output mask, pending, cpu_int, int_id
   );

endinterface

// File: rtl/irq_priority_encoder.sv
// Lowest-index-wins priority encoder; id is zero-extended to ID_WIDTH.
module irq_priority_encoder
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned NUM_IRQ  = NUM_IRQ_DEF,
   parameter int unsigned ID_WIDTH = ID_WIDTH_DEF
) (
   input  logic [NUM_IRQ-1:0]  req_i,
   output logic [ID_WIDTH-1:0] id_o,
   output logic                any_o
);

   always_comb begin
      id_o  = '0;
      any_o = |req_i;
      // Walk downwards so the lowest set index is the last one written
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            id_o = ID_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-captured, maskable interrupt controller with a request/ack/done handshake to the CPU.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned NUM_IRQ  = NUM_IRQ_DEF,
   parameter int unsigned ID_WIDTH = ID_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   interrupt_controller_if.slave bus
);

   logic [STATE_W-1:0]  state_q,   state_d;
   logic [NUM_IRQ-1:0]  mask_q,    mask_d;
   logic [NUM_IRQ-1:0]  pending_q, pending_d;
   logic [NUM_IRQ-1:0]  prev_q;
   logic                cpu_int_q, cpu_int_d;
   logic [ID_WIDTH-1:0] int_id_q,  int_id_d;

   logic [NUM_IRQ-1:0]  rise;
   logic [NUM_IRQ-1:0]  ack_clr;
   logic [ID_WIDTH-1:0] sel_id;
   logic                sel_any;

   assign rise = bus.irq_in & ~prev_q;

   irq_priority_encoder #(
      .NUM_IRQ  (NUM_IRQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_prio (
      .req_i (pending_q & mask_q),
      .id_o  (sel_id),
      .any_o (sel_any)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      cpu_int_d = cpu_int_q;
      int_id_d  = int_id_q;
      ack_clr   = '0;
      mask_d    = bus.mask_wr ? bus.mask_data : mask_q;

      case (state_q)
         S_IDLE: begin
            if (sel_any) begin
               int_id_d  = sel_id;
               cpu_int_d = 1'b1;
               state_d   = S_REQUEST;
            end
         end
         S_REQUEST: begin
            if (bus.int_ack) begin
               for (int i = 0; i < int'(NUM_IRQ); i++) begin
                  ack_clr[i] = (int_id_q == ID_WIDTH'(i));
               end
               cpu_int_d = 1'b0;
               state_d   = S_SERVICE;
            end
         end
         S_SERVICE: begin
            if (bus.int_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            cpu_int_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase

      // A new edge on the acknowledged bit wins over the clear
      pending_d = (pending_q & ~ack_clr) | rise;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mask_q    <= '0;
         pending_q <= '0;
         prev_q    <= '0;
         cpu_int_q <= 1'b0;
         int_id_q  <= '0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         pending_q <= pending_d;
         prev_q    <= bus.irq_in;
         cpu_int_q <= cpu_int_d;
         int_id_q  <= int_id_d;
      end
   end

   assign bus.mask    = mask_q;
   assign bus.pending = pending_q;
   assign bus.cpu_int = cpu_int_q;
   assign bus.int_id  = int_id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed, table-driven bench for interrupt_controller; one row = one clock of inputs plus expected outputs after it.
module tb_interrupt_controller;

   localparam int unsigned NI = 8;
   localparam int unsigned IW = 3;

   typedef struct packed {
      logic          rst;
      logic [NI-1:0] irq;
      logic          mwr;
      logic [NI-1:0] mdata;
      logic          ack;
      logic          done;
      logic [NI-1:0] e_pend;
      logic [NI-1:0] e_mask;
      logic          e_cpu;
      logic [IW-1:0] e_id;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   rises;
   logic last_cpu;

   interrupt_controller_if #(.NUM_IRQ(NI), .ID_WIDTH(IW)) bus ();

   interrupt_controller #(.NUM_IRQ(NI), .ID_WIDTH(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
      end
   endtask

   // Apply one row for a clock, then compare outputs just after the edge
   task automatic step(input vec_t v, input int row);
      @(negedge clk);
      reset         = v.rst;
      bus.irq_in    = v.irq;
      bus.mask_wr   = v.mwr;
      bus.mask_data = v.mdata;
      bus.int_ack   = v.ack;
      bus.int_done  = v.done;
      @(posedge clk);
      #1;
      check("pending", row, 32'(bus.pending), 32'(v.e_pend));
      check("mask",    row, 32'(bus.mask),    32'(v.e_mask));
      check("cpu_int", row, 32'(bus.cpu_int), 32'(v.e_cpu));
      check("int_id",  row, 32'(bus.int_id),  32'(v.e_id));
      if (bus.cpu_int && !last_cpu) rises++;
      last_cpu = bus.cpu_int;
   endtask

   vec_t tbl[$];
   vec_t cor[$];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rises    = 0;
      last_cpu = 1'b0;
      reset    = 1'b1;
      bus.irq_in = '0; bus.mask_wr = 1'b0; bus.mask_data = '0;
      bus.int_ack = 1'b0; bus.int_done = 1'b0;

      //             rst  irq   mwr  mdata ack  done  pend  mask  cpu  id
      tbl.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0});
      // single pulse on bit 0
      tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 3'd0});
      tbl.push_back('{1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 3'd0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h01, 1'b1, 3'd0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 3'd0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 3'd0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 3'd0});
      // masked pending, then unmask
      tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0});
      tbl.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 3'd0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 3'd0});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h08, 1'b0, 1'b0, 8'h08, 8'h08, 1'b0, 3'd0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 8'h08, 1'b1, 3'd3});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 3'd3});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h08, 1'b0, 3'd3});
      // simultaneous edges 5 and 2
      tbl.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd3});
      tbl.push_back('{1'b0, 8'h24, 1'b0, 8'h00, 1'b0, 1'b0, 8'h24, 8'hFF, 1'b0, 3'd3});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h24, 8'hFF, 1'b1, 3'd2});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'hFF, 1'b0, 3'd2});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 8'hFF, 1'b0, 3'd2});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 8'hFF, 1'b1, 3'd5});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd5});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd5});
      // id 4 frozen against higher-priority edge, mask writes and stray done
      tbl.push_back('{1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 8'hFF, 1'b0, 3'd5});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 8'hFF, 1'b1, 3'd4});
      tbl.push_back('{1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 8'hFF, 1'b1, 3'd4});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h12, 8'h00, 1'b1, 3'd4});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h12, 8'hFF, 1'b1, 3'd4});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 8'hFF, 1'b0, 3'd4});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 8'hFF, 1'b0, 3'd4});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 8'hFF, 1'b0, 3'd4});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 8'hFF, 1'b1, 3'd1});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd1});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd1});
      // stray ack and done in IDLE
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd1});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd1});

      foreach (tbl[i]) step(tbl[i], i);

      // Level held on bit 6 for 20 cycles: exactly one request
      rises = 0;
      step('{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'hFF, 1'b0, 3'd1}, 100);
      step('{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'hFF, 1'b1, 3'd6}, 101);
      step('{1'b0, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd6}, 102);
      step('{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd6}, 103);
      for (int k = 0; k < 16; k++) begin
         step('{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd6}, 104 + k);
      end
      check("held_level_requests", 120, 32'(rises), 32'd1);

      // Ack coincides with a fresh edge on bit 6, reset in SERVICE, no request after reset
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd6});
      cor.push_back('{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'hFF, 1'b0, 3'd6});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'hFF, 1'b1, 3'd6});
      cor.push_back('{1'b0, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 8'hFF, 1'b0, 3'd6});
      cor.push_back('{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 8'hFF, 1'b0, 3'd6});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'hFF, 1'b1, 3'd6});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd6});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd6});
      cor.push_back('{1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'hFF, 1'b0, 3'd6});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'hFF, 1'b1, 3'd0});
      cor.push_back('{1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'hFF, 1'b0, 3'd0});
      cor.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0});
      cor.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd0});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd0});
      cor.push_back('{1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 8'hFF, 1'b0, 3'd0});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 8'hFF, 1'b1, 3'd2});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd2});
      cor.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd2});

      foreach (cor[i]) step(cor[i], 200 + i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Consumer side of the peripheral interrupt lines, including the one-shot timer's single-cycle interrupt pulse.
- Captures rising edges from NUM_IRQ sources into pending bits and applies a software mask.
- Selects the highest-priority unmasked pending source and runs a request/acknowledge/done handshake with the CPU.
- Sits between the IO peripherals and the CPU interrupt input.

Parameters:
- NUM_IRQ, 8, number of interrupt source lines.
- ID_WIDTH, 3, width of the interrupt id; must satisfy 2**ID_WIDTH >= NUM_IRQ.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  NUM_IRQ  source lines, pulse or level; only rising edges count.
- mask_wr  input  1  write strobe for the mask register.
- mask_data  input  NUM_IRQ  new mask value; bit=1 enables the source.
- mask  output  NUM_IRQ  current mask register.
- pending  output  NUM_IRQ  current pending register, for CPU readback.
- cpu_int  output  1  interrupt request to the CPU.
- int_id  output  ID_WIDTH  id of the requested source; valid while cpu_int=1.
- int_ack  input  1  CPU accepts the request (1 cycle).
- int_done  input  1  CPU finished the handler (reti, 1 cycle).

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - mask=0, pending=0, cpu_int=0, int_id=0, edge-detect history=0, state=IDLE.
  - Reset mid-handshake aborts it; no request follows reset.
- Edge capture:
  - prev register holds irq_in from the previous cycle.
  - rise = irq_in & ~prev.
  - Rising edge sampled in cycle t sets pending[i] at t+1, regardless of mask.
  - A level held high produces exactly one pending set.
- Mask:
  - mask_wr=1 loads mask_data at the next edge; it takes effect for selection from that cycle on.
  - Masked pending bits stay latched and are requested once unmasked.
- Priority: lowest index wins. sel = lowest i with pending[i] & mask[i].
- State machine, states IDLE, REQUEST, SERVICE:
  - IDLE: if any bit of pending&mask is set, latch int_id=sel, set cpu_int=1, go to REQUEST.
    - Latency: edge sampled at t -> pending at t+1 -> cpu_int=1 at t+2.
  - REQUEST:
    - int_id is frozen; mask writes or new higher-priority edges do not change it; the request stays committed even if masked afterwards.
    - int_ack=1: clear pending[int_id], cpu_int=0 next cycle, go to SERVICE.
  - SERVICE: no request (no nesting). int_done=1 -> IDLE; the next request can assert one cycle after returning to IDLE.
- Boundary conditions:
  - int_ack outside REQUEST is ignored; int_done outside SERVICE is ignored.
  - The ack clear and a new rising edge on the same bit in the same cycle: set wins, pending stays 1.
  - Simultaneous edges on several lines: all latched, serviced in priority order over successive handshakes.
  - An edge arriving during SERVICE is latched and requested after int_done.
  - int_id is zero-extended when NUM_IRQ < 2**ID_WIDTH.

Decomposition:
- Shared package: state encoding localparams S_IDLE=0, S_REQUEST=1, S_SERVICE=2 and the default NUM_IRQ/ID_WIDTH constants.
- One sub-module: irq_priority_encoder.
  - Combinational, NUM_IRQ-bit request vector in.
  - Outputs: ID_WIDTH-bit lowest-set index, plus 1-bit any flag.

Test Plan:
- Reset, write mask=8'h01, pulse irq_in[0] for 1 cycle at t -> pending=8'h01 at t+1, cpu_int=1 and int_id=0 at t+2; ack -> pending=0, cpu_int=0; done -> IDLE.
- mask=8'h00, pulse irq_in[3] -> pending=8'h08, cpu_int stays 0; then write mask=8'h08 -> cpu_int=1 with int_id=3 two cycles after the write.
- mask=8'hFF, edges on irq_in[5] and irq_in[2] in the same cycle -> int_id=2 first; after ack+done, int_id=5 served; pending=0 at end.
- In REQUEST with int_id=4, edge on irq_in[1] -> int_id stays 4 until ack; after done, int_id=1 requested.
- Hold irq_in[6] high for 20 cycles -> exactly one request for id 6. Ack in the same cycle as a new edge on bit 6 -> pending[6] remains 1.
- Assert reset during SERVICE with pending=8'h10 -> pending=0, mask=0, cpu_int=0, state IDLE. Stray int_ack/int_done in IDLE -> no effect.
